fp_mul_sched: RTL and testbench
===============================

Name: fp_mul_sched

Overview:
- Shares one fp_mul (multiply / fused multiply-add) unit between two issue requesters, one per hart.
- Arbitrates round-robin, drives the unit's operand and control inputs, and tracks hart/rd tags alongside the unit's fixed-latency pipeline.
- Buffers results in an output FIFO for a back-pressurable writeback port. Uses credit-based issue so no result is ever lost, and supports a per-hart flush.

Parameters:
- RV, 64, operand/result width (NaN-boxed for fp32/fp16).
- LAT, 2, fp_mul latency in clock edges from mul_start to valid mul_res/mul_exception.
- DEPTH, 4, output FIFO entries; power of 2, must be >= LAT+1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = hart i.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_op  in  2x3  per hart: 0 mul, 1 a*b+c, 2 a*b-c, 3 -(a*b)+c, 4 -(a*b)-c, 5-7 illegal.
- req_sz  in  2x2  per hart: 0 fp32, 1 fp64, 2 fp16.
- req_rnd  in  2x3  rounding mode.
- req_rd  in  2x6  destination register.
- req_in_1, req_in_2, req_in_3  in  2xRV each  operands.
- flush  in  2  kill all outstanding work of hart i.
- mul_start  out  1  issue pulse to fp_mul.
- mul_sz, mul_rnd, mul_in_1, mul_in_2, mul_in_3, mul_fmuladd, mul_fmulsub, mul_fmulsign  out  to fp_mul.
- mul_res  in  RV  unit result.
- mul_exception  in  1  unit exception.
- wb_valid  out  1  writeback valid.
- wb_ready  in  1  writeback accept.
- wb_hart  out  1  hart of the result.
- wb_rd  out  6  destination register.
- wb_res  out  RV  result.
- wb_exception  out  1  exception flag.

Behaviour:
- Reset (async, reset=0):
  - All tag-pipe valids and FIFO pointers/count cleared.
  - RR pointer = 1, so hart 0 wins first.
  - Outputs: req_ready=0, mul_start=0, wb_valid=0, wb_* = 0.
  - Unit outputs are ignored until new issues reach the tag pipe.
- Occupancy = live tag-pipe entries + FIFO count (registered values only).
- Issue is allowed iff occupancy < DEPTH.
- Eligibility: hart i is eligible iff req_valid[i] && !flush[i] && issue allowed.
- Grant:
  - One eligible hart: that hart.
  - Both eligible: the hart != RR pointer.
  - The pointer updates to the granted hart on each grant.
  - req_ready[i] = grant[i] (combinational); handshake = valid && ready.
- Unit drive on grant (legal op):
  - mul_start=1; operands, sz and rnd muxed combinationally from the granted hart.
  - Op 0: fmuladd=0.
  - Op 1: fmuladd=1, fmulsub=0, fmulsign=0.
  - Op 2: fmuladd=1, fmulsub=1, fmulsign=0.
  - Op 3: fmuladd=1, fmulsub=0, fmulsign=1.
  - Op 4: fmuladd=1, fmulsub=1, fmulsign=1.
  - When not granting: mul_start=0 and the other controls are don't-care.
- Illegal op (5-7):
  - Accepted normally with mul_start=0.
  - Tagged "illegal"; on retire, writes res=0, exception=1 to the FIFO.
- Tag pipe:
  - LAT stages of {valid, illegal, hart, rd}.
  - Stage 0 is loaded at the accept edge.
  - At the last stage, mul_res/mul_exception are written into the FIFO at the next edge.
  - Accept in cycle N → wb_valid earliest in cycle N+LAT+1. No bypass.
- FIFO:
  - wb_valid=1 when the head is live.
  - Pop on wb_valid && wb_ready.
  - Simultaneous push and pop is allowed when full; the count is unchanged.
  - Credit rule guarantees no push when full without a pop.
- Flush[h]:
  - In the flush cycle, every tag-pipe entry with hart h has valid cleared; it no longer counts toward occupancy.
  - Every FIFO entry with hart h gets its killed bit set, including an entry being pushed that cycle.
  - A killed head never raises wb_valid. It is popped internally, one per cycle, independent of wb_ready, and counts until popped.
  - The other hart is unaffected. Flush of both harts is allowed.
- Simultaneous flush[h] and req_valid[h]: no accept for h.
- RR pointer is unchanged when there is no grant.
- The unit sees back-to-back issues every cycle when credits allow; full throughput is 1/cycle.

Test Plan:
- Single fp64 op 0, hart 0, rd=5, in_1=4008000000000000, in_2=3FF0000000000000, unit model LAT=2 → wb_valid in cycle N+3 with wb_res=4008000000000000, wb_hart=0, wb_rd=5, wb_exception=0.
- Both harts valid continuously, wb_ready=1 → grants alternate 0,1,0,1; results emerge in issue order with matching hart/rd; one mul_start per cycle.
- wb_ready=0 with both harts valid → exactly DEPTH=4 accepts, then req_ready stays 0. Raising wb_ready resumes issue and delivers all 4 results in order.
- op=3, sz=0, in_1=FFFFFFFF3F800000, in_2=FFFFFFFF40400000, in_3=FFFFFFFF3F800000 → mul_fmuladd=1, mul_fmulsub=0, mul_fmulsign=1 on the issue cycle. op=6 on hart 1 → no mul_start, wb_res=0 and wb_exception=1 after LAT+1 cycles.
- Issue hart0 rd1, hart1 rd2, hart0 rd3, then flush[0] one cycle later → only hart1 rd2 is written back. Occupancy returns to 0 and the FIFO drains with no wb_valid for killed entries.
- Assert reset with 3 operations in flight and the FIFO nonempty → wb_valid=0 immediately. After release, a new request from hart 0 is granted first and its result is the only writeback.

Source files
------------

// File: rtl/fp_mul_sched.sv
// Two-hart scheduler for a shared fixed-latency fp_mul unit: round-robin issue,
// a tag pipe that tracks the unit's latency, and a credit-guarded writeback FIFO.

module fp_mul_sched_lane (
  input  logic       valid,
  input  logic       flush,
  input  logic       issue_ok,
  input  logic [2:0] op,
  output logic       elig,
  output logic       illegal,
  output logic       fmuladd,
  output logic       fmulsub,
  output logic       fmulsign
);
  assign elig     = valid & ~flush & issue_ok;
  assign illegal  = (op > 3'd4);
  assign fmuladd  = (op != 3'd0) & ~illegal;
  assign fmulsub  = (op == 3'd2) | (op == 3'd4);
  assign fmulsign = (op == 3'd3) | (op == 3'd4);
endmodule

module fp_mul_sched #(
  parameter int RV    = 64,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][2:0]     req_op,
  input  logic [1:0][1:0]     req_sz,
  input  logic [1:0][2:0]     req_rnd,
  input  logic [1:0][5:0]     req_rd,
  input  logic [1:0][RV-1:0]  req_in_1,
  input  logic [1:0][RV-1:0]  req_in_2,
  input  logic [1:0][RV-1:0]  req_in_3,
  input  logic [1:0]          flush,
  output logic                mul_start,
  output logic [1:0]          mul_sz,
  output logic [2:0]          mul_rnd,
  output logic [RV-1:0]       mul_in_1,
  output logic [RV-1:0]       mul_in_2,
  output logic [RV-1:0]       mul_in_3,
  output logic                mul_fmuladd,
  output logic                mul_fmulsub,
  output logic                mul_fmulsign,
  input  logic [RV-1:0]       mul_res,
  input  logic                mul_exception,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic                wb_hart,
  output logic [5:0]          wb_rd,
  output logic [RV-1:0]       wb_res,
  output logic                wb_exception
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1);

  typedef struct packed {
    logic       ill;
    logic       hart;
    logic [5:0] rd;
  } tag_t;

  typedef struct packed {
    logic          killed;
    logic          hart;
    logic [5:0]    rd;
    logic [RV-1:0] res;
    logic          exc;
  } fifo_ent_t;

  logic [LAT-1:0] vld_pipe, vld_live;
  tag_t           tag_pipe [LAT];
  fifo_ent_t      fifo [DEPTH];
  fifo_ent_t      push_ent, head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt;
  logic [CW-1:0]  occ;
  logic           rr, issue_ok, accept, gh, push, pop, head_live;
  logic [1:0]     elig, ill, fadd, fsub, fsign, grant;

  // Credits: every live tag entry already owns a FIFO slot
  always_comb begin
    occ = CW'(cnt);
    for (int i = 0; i < LAT; i++) occ = occ + CW'(vld_pipe[i]);
  end
  assign issue_ok = reset & (occ < CW'(DEPTH));

  for (genvar h = 0; h < 2; h++) begin : g_lane
    fp_mul_sched_lane u_lane (
      .valid   (req_valid[h]),
      .flush   (flush[h]),
      .issue_ok(issue_ok),
      .op      (req_op[h]),
      .elig    (elig[h]),
      .illegal (ill[h]),
      .fmuladd (fadd[h]),
      .fmulsub (fsub[h]),
      .fmulsign(fsign[h])
    );
  end

  // rr holds the last granted hart; on contention the other one wins
  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign gh           = grant[1];
  assign accept       = |grant;
  assign req_ready    = grant;
  assign mul_start    = accept & ~ill[gh];
  assign mul_sz       = req_sz[gh];
  assign mul_rnd      = req_rnd[gh];
  assign mul_in_1     = req_in_1[gh];
  assign mul_in_2     = req_in_2[gh];
  assign mul_in_3     = req_in_3[gh];
  assign mul_fmuladd  = fadd[gh];
  assign mul_fmulsub  = fsub[gh];
  assign mul_fmulsign = fsign[gh];

  always_comb begin
    for (int i = 0; i < LAT; i++) vld_live[i] = vld_pipe[i] & ~flush[tag_pipe[i].hart];
  end

  assign push = vld_live[LAT-1];

  always_comb begin
    push_ent        = '0;
    push_ent.killed = flush[tag_pipe[LAT-1].hart];
    push_ent.hart   = tag_pipe[LAT-1].hart;
    push_ent.rd     = tag_pipe[LAT-1].rd;
    push_ent.res    = tag_pipe[LAT-1].ill ? '0 : mul_res;
    push_ent.exc    = tag_pipe[LAT-1].ill | mul_exception;
  end

  // A head killed now or earlier is dropped without waiting on wb_ready
  assign head      = fifo[rd_ptr];
  assign head_live = (cnt != '0) & ~head.killed & ~flush[head.hart];
  assign pop       = (cnt != '0) & (~head_live | wb_ready);

  assign wb_valid     = head_live;
  assign wb_hart      = head_live ? head.hart : 1'b0;
  assign wb_rd        = head_live ? head.rd   : 6'd0;
  assign wb_res       = head_live ? head.res  : '0;
  assign wb_exception = head_live ? head.exc  : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
      rr     <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= '{ill: ill[gh], hart: gh, rd: req_rd[gh]};
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_live[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (accept) rr <= gh;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (push && wr_ptr == AW'(j)) fifo[j] <= push_ent;
      else fifo[j].killed <= fifo[j].killed | flush[fifo[j].hart];
    end
  end
endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched: behavioural fixed-latency unit plus a
// scoreboard of expected writebacks filled at accept time, drained at writeback.
module tb_fp_mul_sched;
  localparam int RV = 64;
  localparam int LAT = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, flush;
  logic [1:0][2:0] req_op, req_rnd;
  logic [1:0][1:0] req_sz;
  logic [1:0][5:0] req_rd;
  logic [1:0][RV-1:0] req_in_1, req_in_2, req_in_3;
  logic mul_start, mul_fmuladd, mul_fmulsub, mul_fmulsign, mul_exception;
  logic [1:0] mul_sz;
  logic [2:0] mul_rnd;
  logic [RV-1:0] mul_in_1, mul_in_2, mul_in_3, mul_res;
  logic wb_valid, wb_ready, wb_hart, wb_exception;
  logic [5:0] wb_rd;
  logic [RV-1:0] wb_res;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        hart;
    logic [5:0]  rd;
    logic [63:0] res;
    logic        exc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_mul_sched #(.RV(RV), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sz(req_sz),
    .req_rnd(req_rnd), .req_rd(req_rd), .req_in_1(req_in_1), .req_in_2(req_in_2),
    .req_in_3(req_in_3), .flush(flush),
    .mul_start(mul_start), .mul_sz(mul_sz), .mul_rnd(mul_rnd), .mul_in_1(mul_in_1),
    .mul_in_2(mul_in_2), .mul_in_3(mul_in_3), .mul_fmuladd(mul_fmuladd),
    .mul_fmulsub(mul_fmulsub), .mul_fmulsign(mul_fmulsign),
    .mul_res(mul_res), .mul_exception(mul_exception),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_hart(wb_hart), .wb_rd(wb_rd),
    .wb_res(wb_res), .wb_exception(wb_exception)
  );

  // Stand-in arithmetic: cheap, operand-sensitive, and identity for a*1.0
  function automatic logic [64:0] model(input logic [63:0] a, b, c,
                                        input logic add, sub, sign);
    logic [63:0] r;
    r = a ^ b ^ 64'h3FF0_0000_0000_0000;
    if (add) r = r ^ c ^ {sub, sign, 62'b0};
    return {a[1] ^ b[1], r};
  endfunction

  logic [LAT-1:0] u_v = '0;
  logic [64:0]    u_r [LAT];
  always @(posedge clk) begin
    u_v[0] <= mul_start;
    u_r[0] <= model(mul_in_1, mul_in_2, mul_in_3, mul_fmuladd, mul_fmulsub, mul_fmulsign);
    for (int i = 1; i < LAT; i++) begin
      u_v[i] <= u_v[i-1];
      u_r[i] <= u_r[i-1];
    end
  end
  assign mul_res       = u_v[LAT-1] ? u_r[LAT-1][63:0] : 64'hBAD0_BAD0_BAD0_BAD0;
  assign mul_exception = u_v[LAT-1] ? u_r[LAT-1][64] : 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t exp_of(input logic h);
    exp_t e;
    logic [2:0] op;
    logic [64:0] m;
    op = req_op[h];
    e.hart = h;
    e.rd = req_rd[h];
    if (op > 3'd4) begin
      e.res = '0;
      e.exc = 1'b1;
    end else begin
      m = model(req_in_1[h], req_in_2[h], req_in_3[h], op != 3'd0,
                op == 3'd2 || op == 3'd4, op == 3'd3 || op == 3'd4);
      e.res = m[63:0];
      e.exc = m[64];
    end
    return e;
  endfunction

  exp_t got;
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) chk("wb_unexpected", 64'(wb_valid), 64'd0);
        else begin
          got = sb.pop_front();
          chk("wb_hart", 64'(wb_hart), 64'(got.hart));
          chk("wb_rd", 64'(wb_rd), 64'(got.rd));
          chk("wb_res", wb_res, got.res);
          chk("wb_exc", 64'(wb_exception), 64'(got.exc));
        end
      end
      for (int h = 0; h < 2; h++)
        if (flush[h])
          for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].hart == 1'(h)) sb.delete(k);
      for (int h = 0; h < 2; h++)
        if (req_valid[h] && req_ready[h]) sb.push_back(exp_of(1'(h)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input logic h, input logic [2:0] op, input logic [1:0] sz,
                         input logic [2:0] rnd, input logic [5:0] rd,
                         input logic [63:0] a, b, c);
    req_op[h] = op; req_sz[h] = sz; req_rnd[h] = rnd; req_rd[h] = rd;
    req_in_1[h] = a; req_in_2[h] = b; req_in_3[h] = c;
  endtask

  task automatic drain(input int n, input string tag);
    repeat (n) cyc();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  int acc;

  initial begin
    rst_n = 1'b0; req_valid = '0; flush = '0; wb_ready = 1'b1;
    req_op = '0; req_sz = '0; req_rnd = '0; req_rd = '0;
    req_in_1 = '0; req_in_2 = '0; req_in_3 = '0;

    // Reset state, with requests pending
    cyc(); req_valid = 2'b11;
    sample();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_res", wb_res, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    cyc(); req_valid = '0; rst_n = 1'b1;

    // Single fp64 multiply, latency N+3
    cyc();
    set_req(1'b0, 3'd0, 2'd1, 3'd3, 6'd5, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd0);
    req_valid = 2'b01;
    sample();
    chk("t1_ready", 64'(req_ready), 64'd1);
    chk("t1_start", 64'(mul_start), 64'd1);
    chk("t1_fmuladd", 64'(mul_fmuladd), 64'd0);
    chk("t1_sz", 64'(mul_sz), 64'd1);
    chk("t1_rnd", 64'(mul_rnd), 64'd3);
    chk("t1_in1", mul_in_1, 64'h4008_0000_0000_0000);
    cyc(); req_valid = '0;
    sample(); chk("t1_wb_n1", 64'(wb_valid), 64'd0);
    cyc(); sample(); chk("t1_wb_n2", 64'(wb_valid), 64'd0);
    cyc(); sample(); chk("t1_wb_n3", 64'(wb_valid), 64'd1);
    drain(3, "t1_drain");

    // Contention: hart 0 won last, so grants go 1,0,1,0...
    for (int i = 0; i < 6; i++) begin
      cyc();
      set_req(1'b0, 3'(i % 5), 2'd1, 3'd0, 6'(10 + i), {32'h4000_0000, 32'(i * 3)},
              64'h3FF0_0000_0000_0002, 64'(i));
      set_req(1'b1, 3'((i + 2) % 5), 2'd0, 3'd1, 6'(20 + i), {32'h4010_0000, 32'(i * 5)},
              64'h3FF0_0000_0000_0000, 64'(i << 4));
      req_valid = 2'b11;
      sample();
      chk("t2_grant", 64'(req_ready), (i % 2 == 0) ? 64'd2 : 64'd1);
      chk("t2_start", 64'(mul_start), 64'd1);
    end
    cyc(); req_valid = '0;
    drain(6, "t2_drain");

    // Back-pressure: exactly DEPTH credits
    wb_ready = 1'b0; acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      set_req(1'b0, 3'd1, 2'd1, 3'd0, 6'(30 + i), 64'(i * 7), 64'h1234, 64'h55);
      set_req(1'b1, 3'd4, 2'd1, 3'd0, 6'(40 + i), 64'(i * 11), 64'h4321, 64'hAA);
      req_valid = 2'b11;
      sample();
      if (req_ready != 2'b00) acc++;
    end
    chk("t3_accepts", 64'(acc), 64'(DEPTH));
    chk("t3_stalled", 64'(req_ready), 64'd0);
    cyc(); wb_ready = 1'b1; acc = 0;
    sample(); if (req_ready != 2'b00) acc++;
    cyc(); sample(); if (req_ready != 2'b00) acc++;
    cyc(); sample(); if (req_ready != 2'b00) acc++;
    chk("t3_resume", 64'(acc != 0), 64'd1);
    cyc(); req_valid = '0;
    drain(10, "t3_drain");

    // Negated FMA controls, then an illegal op
    cyc();
    set_req(1'b0, 3'd3, 2'd0, 3'd1, 6'd7, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_4040_0000,
            64'hFFFF_FFFF_3F80_0000);
    req_valid = 2'b01;
    sample();
    chk("t4_start", 64'(mul_start), 64'd1);
    chk("t4_fmuladd", 64'(mul_fmuladd), 64'd1);
    chk("t4_fmulsub", 64'(mul_fmulsub), 64'd0);
    chk("t4_fmulsign", 64'(mul_fmulsign), 64'd1);
    chk("t4_in3", mul_in_3, 64'hFFFF_FFFF_3F80_0000);
    cyc();
    set_req(1'b1, 3'd6, 2'd1, 3'd0, 6'd9, 64'h1, 64'h2, 64'h3);
    req_valid = 2'b10;
    sample();
    chk("t4_ill_ready", 64'(req_ready), 64'd2);
    chk("t4_ill_start", 64'(mul_start), 64'd0);
    cyc(); req_valid = '0;
    cyc(); cyc(); sample();
    chk("t4_ill_wb", 64'(wb_valid), 64'd1);
    chk("t4_ill_exc", 64'(wb_exception), 64'd1);
    chk("t4_ill_res", wb_res, 64'd0);
    drain(4, "t4_drain");

    // Flush hart 0 with one result in the FIFO and one in the pipe
    cyc(); set_req(1'b0, 3'd0, 2'd1, 3'd0, 6'd1, 64'h11, 64'h22, 64'h0); req_valid = 2'b01;
    cyc(); set_req(1'b1, 3'd1, 2'd1, 3'd0, 6'd2, 64'h33, 64'h44, 64'h55); req_valid = 2'b10;
    cyc(); set_req(1'b0, 3'd2, 2'd1, 3'd0, 6'd3, 64'h66, 64'h77, 64'h88); req_valid = 2'b01;
    cyc(); req_valid = '0; flush = 2'b01;
    sample();
    chk("t5_flush_wb", 64'(wb_valid), 64'd0);
    cyc(); flush = '0;
    drain(6, "t5_drain");
    cyc(); req_valid = 2'b01;
    sample();
    chk("t5_credit_back", 64'(req_ready), 64'd1);
    cyc(); req_valid = '0;
    drain(5, "t5_drain2");

    // Reset with work in flight and a stalled FIFO head
    wb_ready = 1'b0;
    cyc(); set_req(1'b0, 3'd0, 2'd1, 3'd0, 6'd11, 64'h100, 64'h200, 64'h0); req_valid = 2'b01;
    cyc(); set_req(1'b1, 3'd0, 2'd1, 3'd0, 6'd12, 64'h300, 64'h400, 64'h0); req_valid = 2'b10;
    cyc(); set_req(1'b0, 3'd0, 2'd1, 3'd0, 6'd13, 64'h500, 64'h600, 64'h0); req_valid = 2'b01;
    cyc(); req_valid = '0;
    sample();
    chk("t6_fifo_busy", 64'(wb_valid), 64'd1);
    cyc(); rst_n = 1'b0;
    #1;
    chk("t6_rst_wb", 64'(wb_valid), 64'd0);
    cyc(); cyc();
    rst_n = 1'b1; wb_ready = 1'b1;
    set_req(1'b0, 3'd0, 2'd1, 3'd0, 6'd14, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd0);
    set_req(1'b1, 3'd0, 2'd1, 3'd0, 6'd15, 64'h700, 64'h800, 64'h0);
    req_valid = 2'b11;
    sample();
    chk("t6_first_grant", 64'(req_ready), 64'd1);
    cyc(); req_valid = '0;
    drain(6, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
